// File: rtl/delay_line_mc_pkg.sv
// Shared constants for the multi-channel delay line: fine tap width,
// default fine tap limit, config FSM state encoding and a width helper.
package delay_line_mc_pkg;

    localparam int FINE_W       = 3;
    localparam int FINE_MAX_DEF = 5;

    // Config FSM state encoding (also visible on the debug state output).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    // ceil(log2(n)), never less than 1 so a single channel still gets a select bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/delay_line_ch.sv
// One delay channel: shift history, coarse tap select into a registered
// output, in-flight (busy) detection and the per-channel coarse/fine codes.
module delay_line_ch
    import delay_line_mc_pkg::*;
#(
    parameter int COARSE_W = 3
)(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_i,
    input  logic                gate_i,   // force the input bit to 0 (drain/apply)
    input  logic                apply_i,  // load new codes and clear history
    input  logic [COARSE_W-1:0] coarse_i,
    input  logic [FINE_W-1:0]   fine_i,
    output logic                out_o,
    output logic                busy_o,
    output logic [FINE_W-1:0]   fine_o
);

    localparam int DEPTH = 1 << COARSE_W;

    // hist_q[j] holds the input bit sampled j+1 edges ago. Together with the
    // live input (tap 0) this gives DEPTH selectable taps, so coarse=0 is a
    // single register of latency through out_q.
    logic [DEPTH-2:0]    hist_q;
    logic [DEPTH-2:0]    hist_d;
    logic [DEPTH-1:0]    taps;
    logic                in_eff;
    logic                out_q;
    logic [COARSE_W-1:0] coarse_q;
    logic [FINE_W-1:0]   fine_q;

    // Tap vector and next history; apply wipes stale bits that a larger new
    // coarse setting would otherwise expose.
    always_comb begin
        in_eff = in_i & ~gate_i;
        taps   = {hist_q, in_eff};
        hist_d = apply_i ? '0 : taps[DEPTH-2:0];
    end

    // Busy: any history bit that will still reach out_o under the current coarse.
    always_comb begin
        busy_o = 1'b0;
        for (int j = 0; j < DEPTH - 1; j++) begin
            if (j < int'(coarse_q)) begin
                busy_o = busy_o | hist_q[j];
            end
        end
    end

    // History shift register and registered output tap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            out_q  <= taps[coarse_q];
        end
    end

    // Coarse/fine codes change only on apply, when the channel is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coarse_q <= '0;
            fine_q   <= '0;
        end else if (apply_i) begin
            coarse_q <= coarse_i;
            fine_q   <= fine_i;
        end
    end

    assign out_o  = out_q;
    assign fine_o = fine_q;

endmodule

// File: rtl/delay_line_mc.sv
// Multi-channel programmable delay line. A config request drains the target
// channel (its input forced low, dropped ones counted), then applies the new
// coarse delay and fine tap code in one cycle while other channels keep running.
//
// Config handshake: a request transfers on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_ch/cfg_coarse/cfg_fine are latched on that edge.
// cfg_ready is a register (high only in IDLE), so it never depends on cfg_valid
// combinationally; the requester may change or drop cfg_valid at any time.
module delay_line_mc
    import delay_line_mc_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int COARSE_W = 3,
    parameter int FINE_MAX = FINE_MAX_DEF,
    localparam int CH_W    = clog2_min1(NCH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        in_pulse,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [COARSE_W-1:0]   cfg_coarse,
    input  logic [FINE_W-1:0]     cfg_fine,
    output logic [NCH-1:0]        out_pulse,
    output logic [NCH*FINE_W-1:0] fine_sel,
    output logic [NCH-1:0]        busy,
    output logic [7:0]            drop_cnt,
    output logic [1:0]            dbg_state
);

    localparam logic [CH_W:0]   NCH_V   = (CH_W + 1)'(NCH);
    localparam logic [FINE_W-1:0] FMAX_V = FINE_W'(FINE_MAX);

    logic [1:0]          state_q, state_d;
    logic [CH_W-1:0]     tgt_q, tgt_d;
    logic                ok_q, ok_d;
    logic [COARSE_W-1:0] coarse_req_q, coarse_req_d;
    logic [FINE_W-1:0]   fine_req_q, fine_req_d;
    logic [7:0]          drop_q, drop_d;
    logic                ready_q;

    logic                hs;
    logic                ch_ok;
    logic [FINE_W-1:0]   fine_clamped;
    logic [NCH-1:0]      sel;
    logic [NCH-1:0]      gate;
    logic [NCH-1:0]      apply_vec;
    logic                tgt_busy;
    logic                drop_hit;

    // Request decode: handshake, channel range check and fine clamp.
    always_comb begin
        hs           = cfg_valid & ready_q;
        ch_ok        = ({1'b0, cfg_ch} < NCH_V);
        fine_clamped = (cfg_fine > FMAX_V) ? FMAX_V : cfg_fine;
    end

    // Per-channel target select; gating covers both DRAIN and APPLY so an
    // input coinciding with the apply cycle is dropped as well.
    always_comb begin
        sel = '0;
        for (int c = 0; c < NCH; c++) begin
            sel[c] = ok_q && (tgt_q == CH_W'(c));
        end
        gate      = sel & {NCH{state_q != ST_IDLE}};
        apply_vec = sel & {NCH{state_q == ST_APPLY}};
        tgt_busy  = |(busy & sel);
        drop_hit  = |(in_pulse & gate);
    end

    // Config FSM next state and request latch; invalid channels skip DRAIN
    // and pass through an APPLY that touches nothing.
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        ok_d         = ok_q;
        coarse_req_d = coarse_req_q;
        fine_req_d   = fine_req_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    tgt_d        = cfg_ch;
                    ok_d         = ch_ok;
                    coarse_req_d = cfg_coarse;
                    fine_req_d   = fine_clamped;
                    state_d      = ch_ok ? ST_DRAIN : ST_APPLY;
                end
            end
            ST_DRAIN: begin
                if (!tgt_busy) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Saturating drop counter.
    always_comb begin
        drop_d = (drop_hit && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // FSM, request, ready and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tgt_q        <= '0;
            ok_q         <= 1'b0;
            coarse_req_q <= '0;
            fine_req_q   <= '0;
            drop_q       <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            ok_q         <= ok_d;
            coarse_req_q <= coarse_req_d;
            fine_req_q   <= fine_req_d;
            drop_q       <= drop_d;
            ready_q      <= (state_d == ST_IDLE);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        delay_line_ch #(
            .COARSE_W (COARSE_W)
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (rst),
            .in_i     (in_pulse[c]),
            .gate_i   (gate[c]),
            .apply_i  (apply_vec[c]),
            .coarse_i (coarse_req_q),
            .fine_i   (fine_req_q),
            .out_o    (out_pulse[c]),
            .busy_o   (busy[c]),
            .fine_o   (fine_sel[c*FINE_W +: FINE_W])
        );
    end

    assign cfg_ready = ready_q;
    assign drop_cnt  = drop_q;
    assign dbg_state = state_q;

endmodule
